// File: rtl/rf_checkpoint_monitor_if.sv
// ---------------------------------------------------------------------------
// rf_checkpoint_monitor_if
//
// Bundles every non-clock/reset signal of the register-file checkpoint
// monitor: the CPU writeback snoop port, the checkpoint-table configuration
// port, the run control, and the result/diagnostic outputs.
//
// Modports:
//   master : the side that drives writebacks, table writes and start, and
//            observes results (CPU wrapper, test harness).
//   slave  : the monitor itself.
//
// Signals (direction as seen by the monitor):
//   wb_en, wb_addr, wb_data          in   register writeback snoop
//   cfg_we, cfg_idx, cfg_flag,
//   cfg_reg, cfg_expected            in   checkpoint table write
//   start, num_checks                in   run control
//   busy, done, pass, fail,
//   timed_out                        out  run status
//   cur_idx, fail_idx, fail_got,
//   err_count                        out  diagnostics
// ---------------------------------------------------------------------------
interface rf_checkpoint_monitor_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int IDX_W  = 3
);

  // Writeback snoop
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  // Checkpoint table write
  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_idx;
  logic [DATA_W-1:0] cfg_flag;
  logic [ADDR_W-1:0] cfg_reg;
  logic [DATA_W-1:0] cfg_expected;

  // Run control
  logic              start;
  logic [IDX_W:0]    num_checks;

  // Status and diagnostics
  logic              busy;
  logic              done;
  logic              pass;
  logic              fail;
  logic              timed_out;
  logic [IDX_W-1:0]  cur_idx;
  logic [IDX_W-1:0]  fail_idx;
  logic [DATA_W-1:0] fail_got;
  logic [IDX_W:0]    err_count;

  modport master (
    output wb_en, wb_addr, wb_data,
    output cfg_we, cfg_idx, cfg_flag, cfg_reg, cfg_expected,
    output start, num_checks,
    input  busy, done, pass, fail, timed_out,
    input  cur_idx, fail_idx, fail_got, err_count
  );

  modport slave (
    input  wb_en, wb_addr, wb_data,
    input  cfg_we, cfg_idx, cfg_flag, cfg_reg, cfg_expected,
    input  start, num_checks,
    output busy, done, pass, fail, timed_out,
    output cur_idx, fail_idx, fail_got, err_count
  );

endinterface : rf_checkpoint_monitor_if

// File: rtl/rf_checkpoint_monitor.sv
// ---------------------------------------------------------------------------
// rf_checkpoint_monitor
//
// Snoops the CPU register-file writeback port into a shadow register file
// and walks a programmable checkpoint table. Each checkpoint waits until the
// flag register holds the entry's flag value, then compares one shadow
// register against the entry's expected value. The run ends in pass, fail
// or timeout, with diagnostics for the first failing entry.
//
// Build option:
//   RF_MON_CONTINUE_EN  when defined, a mismatch is counted and the walk
//                       carries on to the final entry; when undefined the
//                       first mismatch ends the run.
//
// Ports:
//   clk   in  clock
//   rst   in  synchronous, active-low reset
//   mon   rf_checkpoint_monitor_if.slave (see interface file for signals)
//
// Timing:
//   - A writeback becomes visible to checks the cycle after it is presented.
//   - WAIT -> CHECK takes one cycle once the flag matches; CHECK is one
//     cycle, so back-to-back entries with the same flag cost 2 cycles each.
//   - The timeout counter starts at 0 on start and advances every busy
//     cycle; done with timed_out appears TIMEOUT_CYCLES cycles after start.
//   - pass/fail/timed_out are registered and rise together with done.
// ---------------------------------------------------------------------------
module rf_checkpoint_monitor #(
  parameter int NUM_CHECKS     = 8,
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 5,
  parameter int FLAG_REG       = 20,
  parameter int TIMEOUT_CYCLES = 100,
  parameter int IDX_W          = $clog2(NUM_CHECKS)
) (
  input  logic                   clk,
  input  logic                   rst,
  rf_checkpoint_monitor_if.slave mon
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  // Counter value held during the last busy cycle the budget allows.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] flag;
    logic [ADDR_W-1:0] rsel;
    logic [DATA_W-1:0] expected;
  } entry_t;

  // -------------------------------------------------------------------------
  // Storage
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] shadow_q [NUM_REGS];
  entry_t            tbl_q    [NUM_CHECKS];

  // -------------------------------------------------------------------------
  // Control state
  // -------------------------------------------------------------------------
  state_e            state_q,     state_d;
  logic [IDX_W-1:0]  cur_idx_q,   cur_idx_d;
  logic [IDX_W:0]    num_q,       num_d;
  logic [TMO_W-1:0]  tmo_q,       tmo_d;
  logic              done_q,      done_d;
  logic              pass_q,      pass_d;
  logic              fail_q,      fail_d;
  logic              timed_out_q, timed_out_d;
  logic [IDX_W:0]    err_count_q, err_count_d;
  logic [IDX_W-1:0]  fail_idx_q,  fail_idx_d;
  logic [DATA_W-1:0] fail_got_q,  fail_got_d;

  logic              busy;
  logic              cfg_ok;
  entry_t            cur_entry;
  logic [DATA_W-1:0] chk_val;
  logic              chk_ok;
  logic              is_last;
  logic [IDX_W:0]    err_inc;

  assign busy = (state_q == ST_WAIT) || (state_q == ST_CHECK);

  // Table writes are only taken while no run is in progress, so an entry
  // can never change underneath the walk.
  assign cfg_ok = mon.cfg_we && !busy && (int'(mon.cfg_idx) < NUM_CHECKS);

  // -------------------------------------------------------------------------
  // Shadow register file. x0 is never written, so it reads as 0 forever.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: this memory is deliberately reset -- checks may read a
      // register the CPU never wrote, and that must compare as 0, not X.
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= '0;
      end
    end else if (mon.wb_en && (mon.wb_addr != '0)) begin
      // NOTE: state is always updated with <= so every reader in this cycle
      // sees the pre-edge value regardless of process ordering.
      shadow_q[mon.wb_addr] <= mon.wb_data;
    end
  end

  // -------------------------------------------------------------------------
  // Checkpoint table
  // -------------------------------------------------------------------------
  // NOTE: the table has no reset; it is always programmed before a run, and
  // leaving it out of reset keeps it mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (cfg_ok) begin
      tbl_q[mon.cfg_idx] <= '{flag:     mon.cfg_flag,
                              rsel:     mon.cfg_reg,
                              expected: mon.cfg_expected};
    end
  end

  // -------------------------------------------------------------------------
  // Walk FSM: next-state and result logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case statement so no
    // path can leave it unassigned and infer a latch.
    state_d     = state_q;
    cur_idx_d   = cur_idx_q;
    num_d       = num_q;
    tmo_d       = tmo_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    timed_out_d = timed_out_q;
    err_count_d = err_count_q;
    fail_idx_d  = fail_idx_q;
    fail_got_d  = fail_got_q;

    cur_entry = tbl_q[cur_idx_q];
    chk_val   = shadow_q[cur_entry.rsel];
    chk_ok    = (chk_val == cur_entry.expected);
    is_last   = ({1'b0, cur_idx_q} == (num_q - 1'b1));
    err_inc   = (err_count_q == '1) ? err_count_q : err_count_q + 1'b1;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (mon.start) begin
          // Every result field restarts from a clean slate, including the
          // empty-table case, so pass can never coexist with stale fail data.
          cur_idx_d   = '0;
          num_d       = mon.num_checks;
          tmo_d       = '0;
          pass_d      = 1'b0;
          fail_d      = 1'b0;
          timed_out_d = 1'b0;
          err_count_d = '0;
          fail_idx_d  = '0;
          fail_got_d  = '0;
          if (mon.num_checks == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d = ST_WAIT;
            done_d  = 1'b0;
          end
        end
      end

      ST_WAIT, ST_CHECK: begin
        tmo_d = tmo_q + 1'b1;
        if (tmo_q == TMO_LAST) begin
          // Budget exhausted: overrides a flag match or a check result
          // decided in the same cycle.
          state_d     = ST_DONE;
          done_d      = 1'b1;
          pass_d      = 1'b0;
          timed_out_d = 1'b1;
        end else if (state_q == ST_WAIT) begin
          // Level compare on the registered shadow: a flag that already
          // holds the right value matches on the first WAIT cycle.
          if (shadow_q[FLAG_REG] == cur_entry.flag) begin
            state_d = ST_CHECK;
          end
        end else begin
          if (!chk_ok) begin
            err_count_d = err_inc;
            if (err_count_q == '0) begin
              fail_idx_d = cur_idx_q;
              fail_got_d = chk_val;
            end
          end
`ifdef RF_MON_CONTINUE_EN
          if (is_last) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            pass_d  = (err_count_d == '0);
            fail_d  = (err_count_d != '0);
          end else begin
            cur_idx_d = cur_idx_q + 1'b1;
            state_d   = ST_WAIT;
          end
`else
          if (!chk_ok) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            fail_d  = 1'b1;
          end else if (is_last) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            pass_d  = (err_count_d == '0);
            fail_d  = (err_count_d != '0);
          end else begin
            cur_idx_d = cur_idx_q + 1'b1;
            state_d   = ST_WAIT;
          end
`endif
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Walk FSM: state register (synchronous reset aborts any run silently)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cur_idx_q   <= '0;
      num_q       <= '0;
      tmo_q       <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timed_out_q <= 1'b0;
      err_count_q <= '0;
      fail_idx_q  <= '0;
      fail_got_q  <= '0;
    end else begin
      state_q     <= state_d;
      cur_idx_q   <= cur_idx_d;
      num_q       <= num_d;
      tmo_q       <= tmo_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      timed_out_q <= timed_out_d;
      err_count_q <= err_count_d;
      fail_idx_q  <= fail_idx_d;
      fail_got_q  <= fail_got_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign mon.busy      = busy;
  assign mon.done      = done_q;
  assign mon.pass      = pass_q;
  assign mon.fail      = fail_q;
  assign mon.timed_out = timed_out_q;
  assign mon.cur_idx   = cur_idx_q;
  assign mon.fail_idx  = fail_idx_q;
  assign mon.fail_got  = fail_got_q;
  assign mon.err_count = err_count_q;

endmodule : rf_checkpoint_monitor

// File: tb/tb_rf_checkpoint_monitor.sv
// ---------------------------------------------------------------------------
// tb_rf_checkpoint_monitor
//
// Scoreboard bench for rf_checkpoint_monitor. The stimulus process programs
// the table, schedules writebacks per cycle of a run, computes the expected
// run outcome with a timeline model and pushes it into a queue. A separate
// monitor process spots each accepted start, counts cycles, and pops and
// compares when done rises (or when a reset aborts the run).
// ---------------------------------------------------------------------------
module tb_rf_checkpoint_monitor;

  localparam int NC   = 8;
  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int IW   = 3;
  localparam int FLAG = 20;
  localparam int T    = 100;
  localparam int W    = T + 3;   // cycles driven per run
`ifdef RF_MON_CONTINUE_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  typedef struct {
    bit          aborted;
    bit          busy0;
    int          lat;
    bit          pass;
    bit          fail;
    bit          tmo;
    int          err;
    int          cur;
    int          fidx;
    logic [31:0] fgot;
  } exp_t;

  logic clk;
  logic rst;

  rf_checkpoint_monitor_if #(.DATA_W(DW), .ADDR_W(AW), .IDX_W(IW)) mon_if ();

  rf_checkpoint_monitor #(
    .NUM_CHECKS    (NC),
    .DATA_W        (DW),
    .ADDR_W        (AW),
    .FLAG_REG      (FLAG),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mon(mon_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  exp_t sb[$];

  // Reference state
  logic [31:0] mshadow [32];
  logic [31:0] snap_sh [32];
  logic [31:0] mflag   [NC];
  logic [4:0]  mreg    [NC];
  logic [31:0] mexp    [NC];
  bit          sched_en   [W];
  logic [4:0]  sched_addr [W];
  logic [31:0] sched_data [W];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic flag_error(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  // Shadow contents visible during cycle t of the current run: everything
  // before the run plus writes presented in cycles earlier than t.
  function automatic void snap(input int t);
    for (int a = 0; a < 32; a++) snap_sh[a] = mshadow[a];
    for (int c = 0; c < t && c < W; c++)
      if (sched_en[c] && sched_addr[c] != 5'd0) snap_sh[sched_addr[c]] = sched_data[c];
  endfunction

  // Outcome of a run: entry i enters WAIT at cycle t, matches its flag at
  // the first cycle w >= t, is checked at w+1, and the next entry enters at
  // w+2. Any decision due in cycle T-1 or later loses to the timeout.
  function automatic exp_t model(input int num, input bit abort);
    exp_t e;
    int t, w, c, idx, err;
    bit found, fin;
    logic [31:0] v;
    e = '{default: 0};
    e.busy0 = (num != 0);
    if (abort) begin
      e.aborted = 1'b1;
      return e;
    end
    if (num == 0) begin
      e.pass = 1'b1;
      return e;
    end
    t = 0; err = 0; idx = 0; fin = 1'b0;
    while (!fin) begin
      found = 1'b0;
      w = t;
      while (!found && w <= T - 2) begin
        snap(w);
        if (snap_sh[FLAG] == mflag[idx]) found = 1'b1;
        else w++;
      end
      if (!found || w + 1 == T - 1) begin
        e.tmo = 1'b1; e.lat = T; e.cur = idx; fin = 1'b1;
      end else begin
        c = w + 1;
        snap(c);
        v = snap_sh[mreg[idx]];
        if (v != mexp[idx]) begin
          err++;
          if (err == 1) begin e.fidx = idx; e.fgot = v; end
        end
        e.cur = idx;
        if (idx == num - 1 || (!CONT && v != mexp[idx])) begin
          e.lat = c + 1; e.pass = (err == 0); e.fail = (err != 0); fin = 1'b1;
        end else begin
          idx++;
          t = c + 1;
        end
      end
    end
    e.err = err;
    return e;
  endfunction

  // ---------------------------------------------------------------------
  // Stimulus helpers (all drive right after a rising edge)
  // ---------------------------------------------------------------------
  task automatic do_reset();
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    for (int a = 0; a < 32; a++) mshadow[a] = '0;
  endtask

  task automatic write_entry(input int idx, input logic [31:0] f, input logic [4:0] r,
                             input logic [31:0] x);
    mon_if.cfg_we       = 1'b1;
    mon_if.cfg_idx      = 3'(idx);
    mon_if.cfg_flag     = f;
    mon_if.cfg_reg      = r;
    mon_if.cfg_expected = x;
    @(posedge clk); #1;
    mon_if.cfg_we = 1'b0;
    mflag[idx] = f; mreg[idx] = r; mexp[idx] = x;
  endtask

  task automatic clear_sched();
    for (int c = 0; c < W; c++) begin
      sched_en[c] = 1'b0; sched_addr[c] = '0; sched_data[c] = '0;
    end
  endtask

  task automatic sched(input int c, input logic [4:0] a, input logic [31:0] d);
    sched_en[c] = 1'b1; sched_addr[c] = a; sched_data[c] = d;
  endtask

  task automatic run(input int num, input int abort_at);
    exp_t e;
    e = model(num, abort_at >= 0);
    sb.push_back(e);
    mon_if.start      = 1'b1;
    mon_if.num_checks = 4'(num);
    @(posedge clk); #1;
    mon_if.start = 1'b0;
    for (int c = 0; c < W; c++) begin
      mon_if.wb_en   = sched_en[c];
      mon_if.wb_addr = sched_addr[c];
      mon_if.wb_data = sched_data[c];
      // The monitor is busy in cycle 0, so this table write must be dropped.
      mon_if.cfg_we = (c == 0) && (num != 0);
      if (c == 0) begin
        mon_if.cfg_idx      = 3'($urandom_range(0, NC - 1));
        mon_if.cfg_flag     = $urandom;
        mon_if.cfg_reg      = 5'($urandom);
        mon_if.cfg_expected = $urandom;
      end
      rst = (c == abort_at) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
    end
    mon_if.wb_en  = 1'b0;
    mon_if.cfg_we = 1'b0;
    rst = 1'b1;
    if (abort_at >= 0) begin
      for (int a = 0; a < 32; a++) mshadow[a] = '0;
    end else begin
      for (int c = 0; c < W; c++)
        if (sched_en[c] && sched_addr[c] != 5'd0) mshadow[sched_addr[c]] = sched_data[c];
    end
  endtask

  // ---------------------------------------------------------------------
  // Monitor: detects accepted starts, measures latency, compares results
  // ---------------------------------------------------------------------
  bit   armed      = 1'b0;
  bit   abort_pend = 1'b0;
  int   lat        = 0;

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (armed) begin
        lat++;
        if (lat == 0 && sb.size() > 0) check("busy_cycle0", mon_if.busy, sb[0].busy0);
        if (abort_pend) begin
          armed = 1'b0; abort_pend = 1'b0;
          if (sb.size() == 0) flag_error("abort_without_expectation");
          else begin
            e = sb.pop_front();
            if (!e.aborted) flag_error("unexpected_abort");
            check("abort_busy", mon_if.busy, 0);
            check("abort_done", mon_if.done, 0);
          end
        end else if (!rst) begin
          abort_pend = 1'b1;
        end else if (mon_if.done) begin
          armed = 1'b0;
          if (sb.size() == 0) flag_error("done_without_expectation");
          else begin
            e = sb.pop_front();
            if (e.aborted) flag_error("done_after_abort");
            check("latency",   lat,                e.lat);
            check("pass",      mon_if.pass,        e.pass);
            check("fail",      mon_if.fail,        e.fail);
            check("timed_out", mon_if.timed_out,   e.tmo);
            check("err_count", mon_if.err_count,   e.err);
            check("cur_idx",   mon_if.cur_idx,     e.cur);
            check("fail_idx",  mon_if.fail_idx,    e.fidx);
            check("fail_got",  mon_if.fail_got,    e.fgot);
            check("busy_done", mon_if.busy,        0);
          end
        end else if (lat > T + 5) begin
          armed = 1'b0;
          flag_error("done_never_seen");
          if (sb.size() > 0) e = sb.pop_front();
        end
      end else if (mon_if.start && rst && !mon_if.busy) begin
        armed = 1'b1; lat = -1; abort_pend = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  logic [4:0] addr_pick [5];

  initial begin : stimulus
    addr_pick[0] = 5'd0; addr_pick[1] = 5'd1; addr_pick[2] = 5'd2;
    addr_pick[3] = 5'd3; addr_pick[4] = 5'd20;
    rst = 1'b1;
    mon_if.wb_en = 1'b0; mon_if.wb_addr = '0; mon_if.wb_data = '0;
    mon_if.cfg_we = 1'b0; mon_if.cfg_idx = '0; mon_if.cfg_flag = '0;
    mon_if.cfg_reg = '0; mon_if.cfg_expected = '0;
    mon_if.start = 1'b0; mon_if.num_checks = '0;
    clear_sched();

    // Reset state
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    check("rst_busy",      mon_if.busy,      0);
    check("rst_done",      mon_if.done,      0);
    check("rst_pass",      mon_if.pass,      0);
    check("rst_fail",      mon_if.fail,      0);
    check("rst_timed_out", mon_if.timed_out, 0);
    check("rst_cur_idx",   mon_if.cur_idx,   0);
    check("rst_fail_idx",  mon_if.fail_idx,  0);
    check("rst_fail_got",  mon_if.fail_got,  0);
    check("rst_err_count", mon_if.err_count, 0);
    @(posedge clk); #1;

    // Three-entry walk, all matching
    write_entry(0, 1, 5'd1, 300);
    write_entry(1, 2, 5'd1, 500);
    write_entry(2, 2, 5'd2, 100);
    clear_sched();
    sched(0, 5'd1, 300); sched(2, 5'd20, 1); sched(10, 5'd1, 500);
    sched(12, 5'd2, 100); sched(14, 5'd20, 2);
    run(3, -1);

    // Same table, x2 wrong at the final entry
    do_reset();
    write_entry(0, 1, 5'd1, 300);
    write_entry(1, 2, 5'd1, 500);
    write_entry(2, 2, 5'd2, 100);
    clear_sched();
    sched(0, 5'd1, 300); sched(2, 5'd20, 1); sched(10, 5'd1, 500);
    sched(12, 5'd2, 99); sched(14, 5'd20, 2);
    run(3, -1);

    // Flag never reaches 1: timeout
    do_reset();
    write_entry(0, 1, 5'd1, 300);
    write_entry(1, 2, 5'd1, 500);
    write_entry(2, 2, 5'd2, 100);
    clear_sched();
    sched(0, 5'd1, 300);
    run(3, -1);

    // Write to x0 is discarded
    do_reset();
    write_entry(0, 0, 5'd0, 0);
    clear_sched();
    sched(0, 5'd0, 7);
    run(1, -1);

    // Write landing in the CHECK cycle is not yet visible
    do_reset();
    write_entry(0, 0, 5'd1, 300);
    clear_sched();
    sched(1, 5'd1, 300);
    run(1, -1);

    // Reset while waiting, then an empty run
    do_reset();
    write_entry(0, 1, 5'd1, 300);
    write_entry(1, 2, 5'd1, 500);
    write_entry(2, 2, 5'd2, 100);
    clear_sched();
    run(3, 5);
    clear_sched();
    run(0, -1);

    // Randomized runs
    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 4) == 0) do_reset();
      for (int i = 0; i < NC; i++)
        write_entry(i, 32'($urandom_range(0, 3)), addr_pick[$urandom_range(0, 4)],
                    32'($urandom_range(0, 3)));
      clear_sched();
      for (int c = 0; c < W; c++)
        if ($urandom_range(0, 9) < 4)
          sched(c, ($urandom_range(0, 1) == 0) ? 5'd20 : addr_pick[$urandom_range(0, 4)],
                32'($urandom_range(0, 3)));
      run($urandom_range(0, NC), -1);
    end

    repeat (5) begin @(posedge clk); #1; end
    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rf_checkpoint_monitor

// File: doc/rf_checkpoint_monitor.md
Name: rf_checkpoint_monitor

Overview:
- Synthesizable successor to the bench-only register-file checks: snoops the CPU register-file writeback port and keeps a shadow register file.
- Walks a programmable table of checkpoints. Each checkpoint waits until the flag register holds a given value, then compares one register against an expected value.
- Reports pass, fail or timeout, with diagnostics. Sits beside the cpu in sim and FPGA self-test builds.

Parameters:
- NUM_CHECKS, 8, checkpoint table depth.
- DATA_W, 32, register data width.
- ADDR_W, 5, register index width (2**ADDR_W registers).
- FLAG_REG, 20, index of the flag register.
- TIMEOUT_CYCLES, 100, global cycle budget counted from start; must be ≥1.
- IDX_W, $clog2(NUM_CHECKS), table index width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- wb_en  in  1  register writeback valid.
- wb_addr  in  ADDR_W  writeback destination.
- wb_data  in  DATA_W  writeback data.
- cfg_we  in  1  table write strobe.
- cfg_idx  in  IDX_W  table entry index.
- cfg_flag  in  DATA_W  flag value to wait for.
- cfg_reg  in  ADDR_W  register to check.
- cfg_expected  in  DATA_W  expected value.
- start  in  1  begin a run (1-cycle pulse).
- num_checks  in  IDX_W+1  active entries, sampled on start; 0 means immediate pass.
- busy  out  1  run in progress.
- done  out  1  run finished (sticky until next start or reset).
- pass  out  1  all checks matched.
- fail  out  1  mismatch detected.
- timed_out  out  1  budget exhausted.
- cur_idx  out  IDX_W  entry being waited on or checked.
- fail_idx  out  IDX_W  first failing entry.
- fail_got  out  DATA_W  value read at the first failure.
- err_count  out  IDX_W+1  number of mismatches.

Behaviour:
- Reset (rst==0 at a clk edge):
  - All outputs go to 0 and the state goes to IDLE.
  - All shadow registers are cleared to 0.
  - Table contents are left undefined.
  - Reset mid-run aborts the run; no done is produced.
- Shadow register file:
  - On wb_en, shadow[wb_addr] <= wb_data, except when wb_addr==0; shadow[0] reads as 0 permanently.
  - Updates run in every state, including IDLE.
  - Reads use registered contents, so a write becomes visible the cycle after it is presented.
- Table writes:
  - Accepted only when busy==0 (IDLE or DONE).
  - cfg_we while busy is ignored.
  - cfg_idx ≥ NUM_CHECKS is ignored.
- States: IDLE, WAIT, CHECK, DONE.
- IDLE/DONE on start:
  - If num_checks==0, go to DONE with pass=1.
  - Otherwise: clear done/pass/fail/timed_out/err_count/fail_idx/fail_got; set cur_idx=0 and timeout counter=0; go to WAIT with busy=1.
- WAIT:
  - When shadow[FLAG_REG]==table[cur_idx].flag (a level compare on the registered shadow), go to CHECK next cycle.
- CHECK (one cycle):
  - Compare shadow[table[cur_idx].reg] with expected.
  - On match: if cur_idx==num_checks-1, go to DONE with pass=1; else increment cur_idx.
    - If the next entry has the same flag, its WAIT matches immediately, giving 2 cycles per entry.
  - On mismatch: increment err_count. On the first mismatch, latch fail_idx=cur_idx and fail_got=value read. Then handle per Optional Feature.
- Timeout:
  - The counter increments every busy cycle.
  - When it reaches TIMEOUT_CYCLES while in WAIT or CHECK: timed_out=1, done=1, pass=0, go to DONE.
  - Timeout takes priority over a same-cycle CHECK result.
- DONE:
  - busy=0, done=1; results hold until the next start.
  - start while busy is ignored.
- Timing: pass and fail are registered and assert in the same cycle as done.

Optional Feature:
- Macro: RF_MON_CONTINUE_EN.
- Defined:
  - A mismatch does not stop the run; cur_idx advances as on a match.
  - At the final entry, go to DONE with pass=(err_count==0 after the update) and fail=!pass.
- Undefined:
  - The first mismatch goes directly to DONE with fail=1 and err_count=1.

Test Plan:
- Table {0:(flag 1, x1, 300), 1:(flag 2, x1, 500), 2:(flag 2, x2, 100)}, num_checks=3.
  - Stimulus: writes x1=300, x20=1, x1=500, x2=100, x20=2.
  - Response: done=1, pass=1, err_count=0, cur_idx=2.
- Same table, but x2=99 is written before x20=2.
  - Without macro: fail=1, fail_idx=2, fail_got=99, err_count=1.
  - With macro: same failure report, and the run completes through the final entry.
- Same table; x20 is never written.
  - Response: timed_out=1, done=1, pass=0 exactly TIMEOUT_CYCLES cycles after start.
- Write to x0 (wb_addr=0, data 7); entry (flag 0, x0, 0) with num_checks=1.
  - Response: pass=1. Shadow x0 stays 0.
- Same-cycle cases:
  - wb write to x1=300 in the same cycle as CHECK of x1 sees the old value, so the check fails.
  - cfg_we while busy leaves the table unchanged.
- rst=0 asserted while in WAIT.
  - Response: next cycle busy=0, done=0.
  - A following start with num_checks=0 gives done=1, pass=1 one cycle later.
